// File: rtl/pc_fetch_unit_pkg.sv
// ============================================================================
// Module      : pc_fetch_unit_pkg
// Description : Shared defaults, next-PC select encodings and helpers for the
//               PC fetch unit.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package pc_fetch_unit_pkg;

  localparam logic [31:0] c_RESET_PC_DEFAULT  = 32'h0000_0000;
  localparam int unsigned c_MEM_WORDS_DEFAULT = 100;

  typedef enum logic [1:0] {
    NPC_SEQ = 2'd0,
    NPC_BR  = 2'd1,
    NPC_J   = 2'd2,
    NPC_JR  = 2'd3
  } npc_sel_e;

  // Word offset -> sign-extended byte offset.
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

`default_nettype wire

// File: rtl/pc_fetch_unit_next_pc_sel.sv
// ============================================================================
// Module      : pc_fetch_unit_next_pc_sel
// Description : Combinational successor-PC selection: priority encode of the
//               select inputs, target computation and jr alignment flag.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module pc_fetch_unit_next_pc_sel
  import pc_fetch_unit_pkg::*;
(
  input  logic [31:0] i_pc,
  input  logic        i_branch_taken,
  input  logic        i_jump,
  input  logic        i_jump_reg,
  input  logic [15:0] i_imm,
  input  logic [25:0] i_target,
  input  logic [31:0] i_reg_data,
  output logic [31:0] o_pc_plus4,
  output logic [31:0] o_next_pc,
  output npc_sel_e    o_sel,
  output logic        o_misalign
);

  logic [31:0] w_pc_plus4;

  assign w_pc_plus4 = i_pc + 32'd4;
  assign o_pc_plus4 = w_pc_plus4;

  // Raw alignment of the register operand; the caller qualifies it with the jr select.
  assign o_misalign = |i_reg_data[1:0];

  always_comb begin
    o_sel     = NPC_SEQ;
    o_next_pc = w_pc_plus4;
    if (i_jump_reg) begin
      o_sel     = NPC_JR;
      o_next_pc = i_reg_data;
    end else if (i_jump) begin
      o_sel     = NPC_J;
      o_next_pc = {w_pc_plus4[31:28], i_target, 2'b00};
    end else if (i_branch_taken) begin
      o_sel     = NPC_BR;
      o_next_pc = w_pc_plus4 + branch_offset(i_imm);
    end
  end

endmodule

`default_nettype wire

// File: rtl/pc_fetch_unit.sv
// ============================================================================
// Module      : pc_fetch_unit
// Description : Program counter, halt/fault detection and retired-instruction
//               counter feeding instruction memory.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = c_RESET_PC_DEFAULT,
  parameter int unsigned MEM_WORDS   = c_MEM_WORDS_DEFAULT,
  parameter int          COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall,
  input  logic                   branch_taken,
  input  logic                   jump,
  input  logic                   jump_reg,
  input  logic [15:0]            imm,
  input  logic [25:0]            target,
  input  logic [31:0]            reg_data,
  output logic [31:0]            pc,
  output logic [31:0]            fetch_addr,
  output logic [31:0]            pc_plus4,
  output logic                   halted,
  output logic                   fault,
  output logic [COUNT_WIDTH-1:0] instr_count
);

  localparam logic [29:0] c_MEM_LIMIT = 30'(MEM_WORDS);

  logic [31:0]            r_pc;
  logic                   r_halted;
  logic                   r_fault;
  logic [COUNT_WIDTH-1:0] r_count;

  logic [31:0] w_pc_plus4;
  logic [31:0] w_next_pc;
  npc_sel_e    w_sel;
  logic        w_misalign;
  logic        w_jr_fault;
  logic        w_out_of_range;

  pc_fetch_unit_next_pc_sel u_next_pc_sel (
    .i_pc           (r_pc),
    .i_branch_taken (branch_taken),
    .i_jump         (jump),
    .i_jump_reg     (jump_reg),
    .i_imm          (imm),
    .i_target       (target),
    .i_reg_data     (reg_data),
    .o_pc_plus4     (w_pc_plus4),
    .o_next_pc      (w_next_pc),
    .o_sel          (w_sel),
    .o_misalign     (w_misalign)
  );

  // A misaligned jr is checked first so it reports a fault even if also out of range.
  assign w_jr_fault     = (w_sel == NPC_JR) && w_misalign;
  assign w_out_of_range = (w_next_pc[31:2] >= c_MEM_LIMIT);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc     <= RESET_PC;
      r_halted <= 1'b0;
      r_fault  <= 1'b0;
      r_count  <= '0;
    end else if (!r_halted && !stall) begin
      if (w_jr_fault) begin
        r_halted <= 1'b1;
        r_fault  <= 1'b1;
      end else if (w_out_of_range) begin
        r_halted <= 1'b1;
      end else begin
        r_pc    <= w_next_pc;
        r_count <= r_count + COUNT_WIDTH'(1);
      end
    end
  end

  assign pc          = r_pc;
  assign fetch_addr  = {2'b00, r_pc[31:2]};
  assign pc_plus4    = w_pc_plus4;
  assign halted      = r_halted;
  assign fault       = r_fault;
  assign instr_count = r_count;

endmodule

`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
// ============================================================================
// Module      : tb_pc_fetch_unit
// Description : Self-checking bench for pc_fetch_unit with a behavioural model,
//               directed scenarios and randomized stimulus.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pc_fetch_unit;

  localparam int MEMW = 100;

  logic        clk = 1'b0;
  logic        reset, stall, branch_taken, jump, jump_reg;
  logic [15:0] imm;
  logic [25:0] target;
  logic [31:0] reg_data;
  logic [31:0] pc, fetch_addr, pc_plus4, instr_count;
  logic        halted, fault;

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural model state
  logic [31:0] m_pc;
  logic        m_halted, m_fault;
  logic [31:0] m_count;

  pc_fetch_unit #(
    .RESET_PC    (32'h0),
    .MEM_WORDS   (MEMW),
    .COUNT_WIDTH (32)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .branch_taken (branch_taken),
    .jump         (jump),
    .jump_reg     (jump_reg),
    .imm          (imm),
    .target       (target),
    .reg_data     (reg_data),
    .pc           (pc),
    .fetch_addr   (fetch_addr),
    .pc_plus4     (pc_plus4),
    .halted       (halted),
    .fault        (fault),
    .instr_count  (instr_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Successor according to the architectural rules, in plain integer arithmetic.
  task automatic model_step(input logic rs, st, br, j, jr, input logic [15:0] im,
                            input logic [25:0] tg, input logic [31:0] rd);
    logic [31:0] seq, np;
    int          off;
    if (rs) begin
      m_pc = 0; m_halted = 0; m_fault = 0; m_count = 0;
    end else if (!m_halted && !st) begin
      seq = m_pc + 4;
      off = $signed(im);
      if (jr)      np = rd;
      else if (j)  np = (seq & 32'hF000_0000) + 32'(tg) * 4;
      else if (br) np = seq + 32'(off * 4);
      else         np = seq;
      if (jr && (rd % 4 != 0)) begin
        m_halted = 1; m_fault = 1;
      end else if (np / 4 >= MEMW) begin
        m_halted = 1;
      end else begin
        m_pc = np; m_count = m_count + 1;
      end
    end
  endtask

  task automatic cyc(input logic rs, st, br, j, jr, input logic [15:0] im,
                     input logic [25:0] tg, input logic [31:0] rd);
    reset = rs; stall = st; branch_taken = br; jump = j; jump_reg = jr;
    imm = im; target = tg; reg_data = rd;
    model_step(rs, st, br, j, jr, im, tg, rd);
    @(posedge clk);
    #1;
    chk("pc", pc, m_pc);
    chk("fetch_addr", fetch_addr, m_pc / 4);
    chk("pc_plus4", pc_plus4, m_pc + 4);
    chk("halted", {31'b0, halted}, {31'b0, m_halted});
    chk("fault", {31'b0, fault}, {31'b0, m_fault});
    chk("instr_count", instr_count, m_count);
  endtask

  task automatic do_reset();
    cyc(1, 0, 0, 0, 0, 16'h0, 26'h0, 32'h0);
  endtask

  task automatic seq_n(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 16'h0, 26'h0, 32'h0);
  endtask

  initial begin
    reset = 1; stall = 0; branch_taken = 0; jump = 0; jump_reg = 0;
    imm = 0; target = 0; reg_data = 0;

    // Reset then free-run: pc 0..20
    do_reset();
    chk("rst_pc", pc, 32'd0);
    chk("rst_count", instr_count, 32'd0);
    for (int i = 1; i <= 5; i++) begin
      seq_n(1);
      chk("seq_pc", pc, 32'(4 * i));
      chk("seq_fetch", fetch_addr, 32'(i));
    end
    chk("seq_count5", instr_count, 32'd5);
    chk("seq_halted", {31'b0, halted}, 32'd0);

    // Backward and forward branches from pc=8
    do_reset(); seq_n(2);
    cyc(0, 0, 1, 0, 0, 16'hFFFE, 26'h0, 32'h0);
    chk("br_back", pc, 32'd4);
    seq_n(1);
    cyc(0, 0, 1, 0, 0, 16'h0003, 26'h0, 32'h0);
    chk("br_fwd", pc, 32'd24);

    // Jump from 12 and jr-beats-jump
    do_reset(); seq_n(3);
    chk("jal_link", pc_plus4, 32'd16);
    cyc(0, 0, 0, 1, 0, 16'h0, 26'h10, 32'h0);
    chk("jump", pc, 32'h40);
    do_reset(); seq_n(3);
    cyc(0, 0, 1, 1, 1, 16'h5, 26'h10, 32'h20);
    chk("jr_wins", pc, 32'h20);

    // Stall holds pc and count
    do_reset(); seq_n(5);
    for (int i = 0; i < 3; i++) cyc(0, 1, 1, 0, 0, 16'h0004, 26'h0, 32'h0);
    chk("stall_pc", pc, 32'd20);
    chk("stall_count", instr_count, 32'd5);
    seq_n(1);
    chk("stall_release", pc, 32'd24);

    // Misaligned jr: sticky halt with fault
    cyc(0, 0, 0, 0, 1, 16'h0, 26'h0, 32'h22);
    chk("mis_pc", pc, 32'd24);
    chk("mis_halted", {31'b0, halted}, 32'd1);
    chk("mis_fault", {31'b0, fault}, 32'd1);
    cyc(0, 0, 0, 1, 0, 16'h0, 26'h4, 32'h0);
    seq_n(2);
    chk("mis_frozen", pc, 32'd24);
    do_reset();
    chk("mis_rst_fault", {31'b0, fault}, 32'd0);

    // Run off the end: 392 -> 396 (word 99) ok, 400 halts
    cyc(0, 0, 0, 1, 0, 16'h0, 26'd98, 32'h0);
    chk("end_392", pc, 32'd392);
    seq_n(2);
    chk("end_pc", pc, 32'd396);
    chk("end_halted", {31'b0, halted}, 32'd1);
    chk("end_fault", {31'b0, fault}, 32'd0);

    // Mid-run reset at pc=100
    do_reset();
    cyc(0, 0, 0, 1, 0, 16'h0, 26'd25, 32'h0);
    chk("mid_pc100", pc, 32'd100);
    do_reset();
    chk("mid_rst_pc", pc, 32'd0);
    chk("mid_rst_count", instr_count, 32'd0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic        rs, st, br, j, jr;
      logic [15:0] im;
      logic [25:0] tg;
      logic [31:0] rd;
      rs = m_halted ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 99) == 0);
      st = ($urandom_range(0, 4) == 0);
      br = ($urandom_range(0, 2) == 0);
      j  = ($urandom_range(0, 7) == 0);
      jr = ($urandom_range(0, 9) == 0);
      im = 16'($urandom_range(0, 60)) - 16'd30;
      tg = 26'($urandom_range(0, 110));
      rd = 32'($urandom_range(0, 110)) * 4;
      if ($urandom_range(0, 5) == 0) rd = rd | 32'($urandom_range(1, 3));
      if ($urandom_range(0, 30) == 0) rd = $urandom;
      cyc(rs, st, br, j, jr, im, tg, rd);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
